// File: rtl/instr_fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller: marker words, limits, state encoding,
// and the saturating word-count helper.
package instr_fetch_ctrl_pkg;

   localparam int          IWIDTH_DEF      = 32;
   localparam int          FIFO_DEPTH_DEF  = 4;
   localparam logic [31:0] START_WORD_DEF  = 32'hA5A5_0001;
   localparam logic [31:0] STOP_WORD_DEF   = 32'hA5A5_00FF;
   localparam int          SEEK_MAX_DEF    = 64;
   localparam int          ACK_TIMEOUT_DEF = 8;
   localparam int          CNT_W           = 16;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_SEEK_REQ  = 3'd1,
      ST_SEEK_WAIT = 3'd2,
      ST_RUN_REQ   = 3'd3,
      ST_RUN_WAIT  = 3'd4,
      ST_DONE      = 3'd5,
      ST_ERROR     = 3'd6
   } fetch_state_e;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

endpackage

// File: rtl/instr_fetch_ctrl_if.sv
// Transmitter link (syn/instr/ack) and decode-stage link (instr/valid/ready) of the fetch controller.
// master = controller side, slave = transmitter + consumer side.
interface instr_fetch_ctrl_if
   import instr_fetch_ctrl_pkg::*;
#(
   parameter int IWIDTH = IWIDTH_DEF
) ();
   logic              f_o_syn;
   logic [IWIDTH-1:0] f_i_instr;
   logic              f_i_ack;
   logic [IWIDTH-1:0] f_o_instr;
   logic              f_o_valid;
   logic              f_i_ready;

   modport master (
      output f_o_syn, f_o_instr, f_o_valid,
      input  f_i_instr, f_i_ack, f_i_ready
   );

   modport slave (
      input  f_o_syn, f_o_instr, f_o_valid,
      output f_i_instr, f_i_ack, f_i_ready
   );
endinterface

// File: rtl/instr_fetch_ctrl_fifo.sv
// instr_fifo: first-word-fall-through ring buffer; a push is visible at the head the next cycle.
// Push is refused when full; pop on empty is ignored; flush empties it synchronously.
module instr_fifo
   import instr_fetch_ctrl_pkg::*;
#(
   parameter int IWIDTH     = IWIDTH_DEF,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
   input  logic              f_clk,
   input  logic              f_rst,
   input  logic              flush,
   input  logic              push_vld,
   input  logic [IWIDTH-1:0] push_dat,
   input  logic              pop_rdy,
   output logic [IWIDTH-1:0] head_dat,
   output logic              head_vld,
   output logic              full
);
   localparam int AW = $clog2(FIFO_DEPTH);

   logic [IWIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]       occ_q, occ_d;
   logic              push_ok, pop_ok;

   assign head_vld = (occ_q != '0);
   assign full     = (occ_q == (AW+1)'(FIFO_DEPTH));
   assign head_dat = head_vld ? mem_q[rd_ptr_q] : '0;
   assign push_ok  = push_vld && !full;
   assign pop_ok   = pop_rdy && head_vld;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         occ_d    = '0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   occ_d = occ_q + (AW+1)'(1);
            2'b01:   occ_d = occ_q - (AW+1)'(1);
            default: occ_d = occ_q;
         endcase
      end
   end

   always_ff @(posedge f_clk or negedge f_rst) begin
      if (!f_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
      end
   end

   // Storage needs no reset: the head is masked to zero whenever the buffer is empty.
   always_ff @(posedge f_clk) begin
      if (push_ok && !flush) mem_q[wr_ptr_q] <= push_dat;
   end
endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: pulses syn, captures acked words, seeks START, buffers until STOP; 2 cycles/word.
// Requests stop while the buffer is full; a missing ack or a failed seek ends in ERROR.
module instr_fetch_ctrl
   import instr_fetch_ctrl_pkg::*;
#(
   parameter int          IWIDTH      = IWIDTH_DEF,
   parameter int          FIFO_DEPTH  = FIFO_DEPTH_DEF,
   parameter logic [31:0] START_WORD  = START_WORD_DEF,
   parameter logic [31:0] STOP_WORD   = STOP_WORD_DEF,
   parameter int          SEEK_MAX    = SEEK_MAX_DEF,
   parameter int          ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
   input  logic                f_clk,
   input  logic                f_rst,
   input  logic                f_i_start,
   instr_fetch_ctrl_if.master  bus,
   output logic                f_o_busy,
   output logic                f_o_done,
   output logic                f_o_err,
   output logic [CNT_W-1:0]    f_o_count
);
   localparam int SW = $clog2(SEEK_MAX + 1);
   localparam int TW = $clog2(ACK_TIMEOUT + 1);

   fetch_state_e     state_q, state_d;
   logic [SW-1:0]    seek_cnt_q, seek_cnt_d;
   logic [TW-1:0]    tmo_cnt_q, tmo_cnt_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic             flush, push, fifo_full;

   instr_fifo #(.IWIDTH(IWIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .f_clk    (f_clk),
      .f_rst    (f_rst),
      .flush    (flush),
      .push_vld (push),
      .push_dat (bus.f_i_instr),
      .pop_rdy  (bus.f_i_ready),
      .head_dat (bus.f_o_instr),
      .head_vld (bus.f_o_valid),
      .full     (fifo_full)
   );

   // The request pulse lasts exactly the one cycle spent in a *_REQ state that is allowed to issue.
   assign bus.f_o_syn = (state_q == ST_SEEK_REQ) || ((state_q == ST_RUN_REQ) && !fifo_full);
   assign f_o_busy    = busy_q;
   assign f_o_done    = done_q;
   assign f_o_err     = err_q;
   assign f_o_count   = count_q;

   always_comb begin
      state_d    = state_q;
      seek_cnt_d = seek_cnt_q;
      tmo_cnt_d  = tmo_cnt_q;
      count_d    = count_q;
      flush      = 1'b0;
      push       = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE, ST_ERROR: begin
            if (f_i_start) begin
               state_d    = ST_SEEK_REQ;
               flush      = 1'b1;
               count_d    = '0;
               seek_cnt_d = '0;
               tmo_cnt_d  = '0;
            end
         end
         ST_SEEK_REQ: begin
            state_d   = ST_SEEK_WAIT;
            tmo_cnt_d = '0;
         end
         ST_RUN_REQ: begin
            tmo_cnt_d = '0;
            if (!fifo_full) state_d = ST_RUN_WAIT;
         end
         ST_SEEK_WAIT, ST_RUN_WAIT: begin
            if (bus.f_i_ack) begin
               tmo_cnt_d = '0;
               if (state_q == ST_SEEK_WAIT) begin
                  if (bus.f_i_instr == START_WORD) begin
                     state_d = ST_RUN_REQ;
                  end else begin
                     seek_cnt_d = seek_cnt_q + SW'(1);
                     state_d    = (seek_cnt_d == SW'(SEEK_MAX)) ? ST_ERROR : ST_SEEK_REQ;
                  end
               end else if (bus.f_i_instr == STOP_WORD) begin
                  state_d = ST_DONE;
               end else begin
                  push    = 1'b1;
                  count_d = sat_inc(count_q);
                  state_d = ST_RUN_REQ;
               end
            end else begin
               tmo_cnt_d = tmo_cnt_q + TW'(1);
               if (tmo_cnt_d == TW'(ACK_TIMEOUT)) state_d = ST_ERROR;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d == ST_SEEK_REQ) || (state_d == ST_SEEK_WAIT) ||
               (state_d == ST_RUN_REQ)  || (state_d == ST_RUN_WAIT);
      done_d = (state_d == ST_DONE);
      err_d  = (state_d == ST_ERROR);
   end

   always_ff @(posedge f_clk or negedge f_rst) begin
      if (!f_rst) begin
         state_q    <= ST_IDLE;
         seek_cnt_q <= '0;
         tmo_cnt_q  <= '0;
         count_q    <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         seek_cnt_q <= seek_cnt_d;
         tmo_cnt_q  <= tmo_cnt_d;
         count_q    <= count_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end
endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl with a behavioural transmitter that acks one cycle after syn.
module tb_instr_fetch_ctrl;
   import instr_fetch_ctrl_pkg::*;

   localparam logic [31:0] START = 32'hA5A5_0001;
   localparam logic [31:0] STOP  = 32'hA5A5_00FF;

   logic        f_clk = 1'b0;
   logic        f_rst = 1'b0;
   logic        f_i_start = 1'b0;
   logic        f_o_busy, f_o_done, f_o_err;
   logic [15:0] f_o_count;

   logic        tx_ack = 1'b0;
   logic [31:0] tx_dat = '0;
   logic        rdy = 1'b0;
   logic        tx_en = 1'b1;
   logic        pend = 1'b0;
   logic [31:0] tx_mem [0:127];
   int          tx_len = 0;
   int          tx_idx = 0;
   int          syn_total = 0;
   logic [31:0] popped [$];

   int chk_cnt = 0;
   int pass_cnt = 0;
   int fail_cnt = 0;

   instr_fetch_ctrl_if #(.IWIDTH(32)) bus ();

   assign bus.f_i_ack   = tx_ack;
   assign bus.f_i_instr = tx_dat;
   assign bus.f_i_ready = rdy;

   instr_fetch_ctrl dut (
      .f_clk     (f_clk),
      .f_rst     (f_rst),
      .f_i_start (f_i_start),
      .bus       (bus),
      .f_o_busy  (f_o_busy),
      .f_o_done  (f_o_done),
      .f_o_err   (f_o_err),
      .f_o_count (f_o_count)
   );

   always #5 f_clk = ~f_clk;

   // Monitor: syn pulses, popped words, and the transmitter's request capture.
   always @(negedge f_clk) begin
      if (bus.f_o_syn) syn_total = syn_total + 1;
      if (bus.f_o_valid && bus.f_i_ready) popped.push_back(bus.f_o_instr);
      if (!f_rst) pend = 1'b0;
      else if (tx_en && bus.f_o_syn) pend = 1'b1;
   end

   always @(posedge f_clk) begin
      #1;
      if (pend) begin
         tx_ack = 1'b1;
         tx_dat = (tx_idx < tx_len) ? tx_mem[tx_idx] : 32'h0;
         tx_idx = tx_idx + 1;
         pend   = 1'b0;
      end else begin
         tx_ack = 1'b0;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge f_clk);
      #1;
   endtask

   task automatic pulse_start();
      f_i_start = 1'b1;
      tick();
      f_i_start = 1'b0;
   endtask

   task automatic load5(input logic [31:0] a, b, c, d, e);
      tx_mem[0] = a; tx_mem[1] = b; tx_mem[2] = c; tx_mem[3] = d; tx_mem[4] = e;
      tx_len = 5;
      tx_idx = 0;
   endtask

   task automatic wait_fin(input string tag, input int maxc);
      int n = 0;
      while (!(f_o_done || f_o_err) && n < maxc) begin tick(); n++; end
      check(tag, {31'd0, (f_o_done || f_o_err)}, 32'd1);
   endtask

   task automatic wait_count(input string tag, input int target, input int maxc);
      int n = 0;
      while (f_o_count != target[15:0] && n < maxc) begin tick(); n++; end
      check(tag, {16'd0, f_o_count}, target);
   endtask

   task automatic wait_syn(input string tag, input int maxc);
      int n = 0;
      do begin @(negedge f_clk); n++; end while (!bus.f_o_syn && n < maxc);
      check(tag, {31'd0, bus.f_o_syn}, 32'd1);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_valid"}, {31'd0, bus.f_o_valid}, 32'd0);
      check({tag, "_instr"}, bus.f_o_instr, 32'd0);
      check({tag, "_count"}, {16'd0, f_o_count}, 32'd0);
      check({tag, "_busy"},  {31'd0, f_o_busy}, 32'd0);
      check({tag, "_done"},  {31'd0, f_o_done}, 32'd0);
      check({tag, "_err"},   {31'd0, f_o_err}, 32'd0);
      check({tag, "_syn"},   {31'd0, bus.f_o_syn}, 32'd0);
   endtask

   initial begin
      int sb;
      // Reset values
      repeat (2) @(posedge f_clk);
      #1;
      check_all_zero("reset");
      f_rst = 1'b1;
      tick();

      // Basic program, consumer always ready
      load5(START, 32'h11, 32'h22, 32'h33, STOP);
      popped.delete();
      rdy = 1'b1;
      pulse_start();
      check("t1_busy", {31'd0, f_o_busy}, 32'd1);
      wait_fin("t1_finish", 60);
      check("t1_done", {31'd0, f_o_done}, 32'd1);
      check("t1_count", {16'd0, f_o_count}, 32'd3);
      repeat (3) tick();
      check("t1_npop", popped.size(), 32'd3);
      check("t1_pop0", popped[0], 32'h11);
      check("t1_pop1", popped[1], 32'h22);
      check("t1_pop2", popped[2], 32'h33);

      // Leading junk discarded before START
      load5(32'hDEAD, 32'hBEEF, START, 32'h44, STOP);
      popped.delete();
      pulse_start();
      check("t2_done_clr", {31'd0, f_o_done}, 32'd0);
      wait_fin("t2_finish", 60);
      check("t2_done", {31'd0, f_o_done}, 32'd1);
      check("t2_count", {16'd0, f_o_count}, 32'd1);
      repeat (3) tick();
      check("t2_npop", popped.size(), 32'd1);
      check("t2_pop0", popped[0], 32'h44);

      // Backpressure: buffer fills, requests stop, no loss
      tx_mem[0] = START;
      for (int i = 1; i <= 6; i++) tx_mem[i] = 32'h100 + i;
      tx_mem[7] = STOP;
      tx_len = 8;
      tx_idx = 0;
      popped.delete();
      rdy = 1'b0;
      pulse_start();
      wait_count("t3_fill", 4, 60);
      sb = syn_total;
      repeat (10) tick();
      check("t3_no_syn", syn_total - sb, 32'd0);
      check("t3_valid", {31'd0, bus.f_o_valid}, 32'd1);
      check("t3_head", bus.f_o_instr, 32'h101);
      check("t3_txidx", tx_idx, 32'd5);
      pulse_start();
      check("t3_start_ignored_cnt", {16'd0, f_o_count}, 32'd4);
      check("t3_start_ignored_busy", {31'd0, f_o_busy}, 32'd1);
      rdy = 1'b1;
      wait_fin("t3_finish", 60);
      repeat (4) tick();
      check("t3_count", {16'd0, f_o_count}, 32'd6);
      check("t3_npop", popped.size(), 32'd6);
      for (int i = 0; i < 6; i++) check($sformatf("t3_pop%0d", i), popped[i], 32'h101 + i);

      // Transmitter silent: ERROR exactly ACK_TIMEOUT cycles after the syn pulse
      tx_en = 1'b0;
      pulse_start();
      wait_syn("t4_syn", 5);
      @(posedge f_clk);
      repeat (7) @(posedge f_clk);
      #1;
      check("t4_err_early", {31'd0, f_o_err}, 32'd0);
      tick();
      check("t4_err", {31'd0, f_o_err}, 32'd1);
      check("t4_busy", {31'd0, f_o_busy}, 32'd0);
      check("t4_done", {31'd0, f_o_done}, 32'd0);
      tx_en = 1'b1;

      // Seek limit: 64 non-START words (one of them STOP) then ERROR
      for (int i = 0; i < 64; i++) tx_mem[i] = (i == 10) ? STOP : 32'h1000 + i;
      tx_mem[64] = START;
      tx_len = 65;
      tx_idx = 0;
      popped.delete();
      pulse_start();
      wait_fin("t5_finish", 300);
      check("t5_err", {31'd0, f_o_err}, 32'd1);
      check("t5_txidx", tx_idx, 32'd64);
      check("t5_count", {16'd0, f_o_count}, 32'd0);
      load5(START, 32'h55, STOP, 32'h0, 32'h0);
      pulse_start();
      check("t5_re_count", {16'd0, f_o_count}, 32'd0);
      check("t5_re_valid", {31'd0, bus.f_o_valid}, 32'd0);
      check("t5_re_err", {31'd0, f_o_err}, 32'd0);
      check("t5_re_busy", {31'd0, f_o_busy}, 32'd1);
      wait_fin("t5_re_finish", 60);
      check("t5_re_done", {31'd0, f_o_done}, 32'd1);
      check("t5_re_cnt1", {16'd0, f_o_count}, 32'd1);
      repeat (3) tick();

      // Reset during RUN_WAIT with two words buffered
      load5(START, 32'h66, 32'h77, 32'h88, STOP);
      popped.delete();
      rdy = 1'b0;
      pulse_start();
      wait_count("t6_two", 2, 60);
      wait_syn("t6_syn", 5);
      @(posedge f_clk);
      #2;
      check("t6_pre_valid", {31'd0, bus.f_o_valid}, 32'd1);
      f_rst = 1'b0;
      #1;
      check_all_zero("t6_rst");
      tick();
      f_rst = 1'b1;
      tick();
      check("t6_post_busy", {31'd0, f_o_busy}, 32'd0);
      check("t6_post_valid", {31'd0, bus.f_o_valid}, 32'd0);
      check("t6_post_count", {16'd0, f_o_count}, 32'd0);
      check("t6_post_syn", {31'd0, bus.f_o_syn}, 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
